// File: rtl/mem_arbiter_if.sv
// Memory-side line bus shared by the caches, the arbiter and the slow memory.
// master drives strobes/address/write line; slave returns read line and ready.
`timescale 1ns/1ps
interface mem_arbiter_if;
  logic         read;
  logic         write;
  logic [27:0]  addr;
  logic [127:0] wdata;
  logic [127:0] rdata;
  logic         ready;

  modport master (output read, output write, output addr, output wdata,
                  input  rdata, input  ready);
  modport slave  (input  read, input  write, input  addr, input  wdata,
                  output rdata, output ready);
endinterface

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter sharing one slow-memory port between I-cache and D-cache.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise D-cache wins ties.
`timescale 1ns/1ps
module mem_arbiter (
  input  logic          clk_i,
  input  logic          proc_reset_i,
  mem_arbiter_if.slave  icache_io,
  mem_arbiter_if.slave  dcache_io,
  mem_arbiter_if.master mem_io
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT_I = 2'd1;
  localparam logic [1:0] ST_GRANT_D = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       last_grant_q;
  logic       last_grant_d;
  logic       i_req_s;
  logic       d_req_s;
  logic       tie_to_d_s;

  assign i_req_s = icache_io.read | icache_io.write;
  assign d_req_s = dcache_io.read | dcache_io.write;

  // Tie-break selection
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    tie_to_d_s = ~last_grant_q;
`else
    tie_to_d_s = 1'b1;
`endif
  end

  // Next-state and grant history; a dropped request abandons the grant
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req_s && d_req_s) begin
          if (tie_to_d_s) begin
            state_d      = ST_GRANT_D;
            last_grant_d = 1'b1;
          end else begin
            state_d      = ST_GRANT_I;
            last_grant_d = 1'b0;
          end
        end else if (d_req_s) begin
          state_d      = ST_GRANT_D;
          last_grant_d = 1'b1;
        end else if (i_req_s) begin
          state_d      = ST_GRANT_I;
          last_grant_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT_I: begin
        if (mem_io.ready || !i_req_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GRANT_I;
        end
      end
      ST_GRANT_D: begin
        if (mem_io.ready || !d_req_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GRANT_D;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (proc_reset_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Route the granted side to memory; write wins over read
  always_comb begin
    mem_io.read  = 1'b0;
    mem_io.write = 1'b0;
    mem_io.addr  = 28'd0;
    mem_io.wdata = 128'd0;
    case (state_q)
      ST_GRANT_I: begin
        mem_io.read  = icache_io.read & ~icache_io.write;
        mem_io.write = icache_io.write;
        mem_io.addr  = icache_io.addr;
        mem_io.wdata = icache_io.wdata;
      end
      ST_GRANT_D: begin
        mem_io.read  = dcache_io.read & ~dcache_io.write;
        mem_io.write = dcache_io.write;
        mem_io.addr  = dcache_io.addr;
        mem_io.wdata = dcache_io.wdata;
      end
      default: begin
        mem_io.read  = 1'b0;
        mem_io.write = 1'b0;
        mem_io.addr  = 28'd0;
        mem_io.wdata = 128'd0;
      end
    endcase
  end

  assign icache_io.ready = mem_io.ready & (state_q == ST_GRANT_I);
  assign dcache_io.ready = mem_io.ready & (state_q == ST_GRANT_D);
  assign icache_io.rdata = mem_io.rdata;
  assign dcache_io.rdata = mem_io.rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with an ownership-level reference model
// checked every cycle, plus literal expectations for each scenario.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   cmp_en  = 1'b0;
  int   m_owner = 0;      // 0 none, 1 I-cache, 2 D-cache
  bit   m_last  = 1'b0;   // 0 I, 1 D

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [127:0] PAT_A5 = {16{8'hA5}};
  localparam logic [127:0] PAT_W1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] PAT_W2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

  mem_arbiter_if ibus ();
  mem_arbiter_if dbus ();
  mem_arbiter_if mbus ();

  mem_arbiter dut (
    .clk_i        (clk),
    .proc_reset_i (rst),
    .icache_io    (ibus),
    .dcache_io    (dbus),
    .mem_io       (mbus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit i_wants();
    return ibus.read | ibus.write;
  endfunction

  function automatic bit d_wants();
    return dbus.read | dbus.write;
  endfunction

  // Reference ownership: who holds memory after each edge
  always @(posedge clk) begin
    if (rst) begin
      m_owner <= 0;
      m_last  <= 1'b0;
    end else if (m_owner == 0) begin
      if (i_wants() && d_wants()) begin
        if (RR && m_last) begin
          m_owner <= 1;
          m_last  <= 1'b0;
        end else begin
          m_owner <= 2;
          m_last  <= 1'b1;
        end
      end else if (d_wants()) begin
        m_owner <= 2;
        m_last  <= 1'b1;
      end else if (i_wants()) begin
        m_owner <= 1;
        m_last  <= 1'b0;
      end
    end else if (mbus.ready || (m_owner == 1 ? !i_wants() : !d_wants())) begin
      m_owner <= 0;
    end
  end

  // Every-cycle comparison of DUT outputs with the reference model
  always @(negedge clk) begin
    if (cmp_en) begin
      logic         e_rd, e_wr;
      logic [27:0]  e_addr;
      logic [127:0] e_wdata;
      e_rd = 1'b0; e_wr = 1'b0; e_addr = 28'd0; e_wdata = 128'd0;
      if (m_owner == 1) begin
        e_rd = ibus.read & ~ibus.write; e_wr = ibus.write;
        e_addr = ibus.addr; e_wdata = ibus.wdata;
      end else if (m_owner == 2) begin
        e_rd = dbus.read & ~dbus.write; e_wr = dbus.write;
        e_addr = dbus.addr; e_wdata = dbus.wdata;
      end
      check("model_mem_read",  {127'd0, mbus.read},  {127'd0, e_rd});
      check("model_mem_write", {127'd0, mbus.write}, {127'd0, e_wr});
      check("model_mem_addr",  {100'd0, mbus.addr},  {100'd0, e_addr});
      check("model_mem_wdata", mbus.wdata, e_wdata);
      check("model_i_ready", {127'd0, ibus.ready}, {127'd0, mbus.ready && m_owner == 1});
      check("model_d_ready", {127'd0, dbus.ready}, {127'd0, mbus.ready && m_owner == 2});
      check("model_i_rdata", ibus.rdata, mbus.rdata);
      check("model_d_rdata", dbus.rdata, mbus.rdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ibus.read = 1'b0; ibus.write = 1'b0; ibus.addr = 28'd0; ibus.wdata = 128'd0;
    dbus.read = 1'b0; dbus.write = 1'b0; dbus.addr = 28'd0; dbus.wdata = 128'd0;
    mbus.rdata = 128'h0123; mbus.ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_mem_read",  {127'd0, mbus.read},  128'd0);
    check("rst_mem_write", {127'd0, mbus.write}, 128'd0);
    check("rst_mem_addr",  {100'd0, mbus.addr},  128'd0);
    check("rst_i_rdata",   ibus.rdata, 128'h0123);
    rst = 1'b0;
    cmp_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("idle_strobes", {126'd0, mbus.read, mbus.write}, 128'd0);
      check("idle_readies", {126'd0, ibus.ready, dbus.ready}, 128'd0);
    end
    mbus.ready = 1'b1;
    #1;
    check("idle_ready_ignored", {126'd0, ibus.ready, dbus.ready}, 128'd0);
    step();
    mbus.ready = 1'b0;

    // Single I read
    ibus.read = 1'b1; ibus.addr = 28'h0000010;
    #1;
    check("i_rd_no_strobe_yet", {127'd0, mbus.read}, 128'd0);
    step();
    check("i_rd_strobe", {127'd0, mbus.read}, 128'd1);
    check("i_rd_addr", {100'd0, mbus.addr}, 128'h10);
    repeat (4) step();
    mbus.rdata = PAT_A5; mbus.ready = 1'b1;
    #1;
    check("i_rd_ready", {127'd0, ibus.ready}, 128'd1);
    check("i_rd_rdata", ibus.rdata, PAT_A5);
    check("i_rd_d_ready", {127'd0, dbus.ready}, 128'd0);
    step();
    mbus.ready = 1'b0; ibus.read = 1'b0;
    #1;
    check("i_rd_ready_pulse", {127'd0, ibus.ready}, 128'd0);
    check("i_rd_strobe_low", {127'd0, mbus.read}, 128'd0);
    step();

    // Simultaneous requests, twice in a row
    ibus.read = 1'b1; ibus.addr = 28'h0000020;
    dbus.write = 1'b1; dbus.addr = 28'h0000040; dbus.wdata = PAT_W1;
    step();
    check("tie1_write", {127'd0, mbus.write}, 128'd1);
    check("tie1_read",  {127'd0, mbus.read},  128'd0);
    check("tie1_addr",  {100'd0, mbus.addr},  128'h40);
    check("tie1_wdata", mbus.wdata, PAT_W1);
    step();
    mbus.ready = 1'b1;
    #1;
    check("tie1_d_ready", {126'd0, ibus.ready, dbus.ready}, 128'd1);
    step();
    mbus.ready = 1'b0; dbus.addr = 28'h0000050; dbus.wdata = PAT_W2;
    #1;
    check("tie_gap_strobes", {126'd0, mbus.read, mbus.write}, 128'd0);
    step();
    check("tie2_read",  {127'd0, mbus.read},  {127'd0, RR});
    check("tie2_write", {127'd0, mbus.write}, {127'd0, !RR});
    check("tie2_addr",  {100'd0, mbus.addr},  RR ? 128'h20 : 128'h50);
    mbus.ready = 1'b1;
    #1;
    check("tie2_readies", {126'd0, ibus.ready, dbus.ready}, RR ? 128'd2 : 128'd1);
    step();
    mbus.ready = 1'b0;
    ibus.read  = RR ? 1'b0 : 1'b1;
    dbus.write = RR ? 1'b1 : 1'b0;
    step();
    check("tie3_read",  {127'd0, mbus.read},  {127'd0, !RR});
    check("tie3_write", {127'd0, mbus.write}, {127'd0, RR});
    check("tie3_addr",  {100'd0, mbus.addr},  RR ? 128'h50 : 128'h20);
    mbus.ready = 1'b1;
    #1;
    check("tie3_readies", {126'd0, ibus.ready, dbus.ready}, RR ? 128'd1 : 128'd2);
    step();
    mbus.ready = 1'b0; ibus.read = 1'b0; dbus.write = 1'b0;
    step();

    // Back-to-back D: write-back then allocate
    dbus.write = 1'b1; dbus.addr = 28'h0000080; dbus.wdata = PAT_W2;
    step();
    check("b2b_write", {127'd0, mbus.write}, 128'd1);
    check("b2b_wdata", mbus.wdata, PAT_W2);
    step();
    mbus.ready = 1'b1;
    step();
    mbus.ready = 1'b0; dbus.write = 1'b0; dbus.read = 1'b1; dbus.addr = 28'h0000090;
    #1;
    check("b2b_gap", {126'd0, mbus.read, mbus.write}, 128'd0);
    step();
    check("b2b_read", {126'd0, mbus.read, mbus.write}, 128'd2);
    check("b2b_addr", {100'd0, mbus.addr}, 128'h90);
    mbus.ready = 1'b1;
    step();
    mbus.ready = 1'b0; dbus.read = 1'b0;
    step();

    // Reset mid-transfer
    ibus.read = 1'b1; ibus.addr = 28'h0000030;
    step();
    check("rstmid_granted", {127'd0, mbus.read}, 128'd1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rstmid_strobe_low", {126'd0, mbus.read, mbus.write}, 128'd0);
    ibus.read = 1'b0;
    step();
    mbus.ready = 1'b1;
    #1;
    check("rstmid_no_ready", {126'd0, ibus.ready, dbus.ready}, 128'd0);
    step();
    mbus.ready = 1'b0;

    // Illegal: both strobes from one requester
    dbus.read = 1'b1; dbus.write = 1'b1; dbus.addr = 28'h0000060;
    for (int k = 0; k < 3; k++) begin
      step();
      check("both_strobes", {126'd0, mbus.read, mbus.write}, 128'd1);
    end
    mbus.ready = 1'b1;
    step();
    mbus.ready = 1'b0; dbus.read = 1'b0; dbus.write = 1'b0;
    step();

    // Abandoned request: strobe falls in the same cycle
    ibus.read = 1'b1; ibus.addr = 28'h0000070;
    step();
    check("abandon_granted", {127'd0, mbus.read}, 128'd1);
    ibus.read = 1'b0;
    #1;
    check("abandon_drop", {127'd0, mbus.read}, 128'd0);
    step();
    dbus.read = 1'b1; dbus.addr = 28'h0000078;
    step();
    check("abandon_next_d", {126'd0, mbus.read, dbus.ready}, 128'd2);
    mbus.ready = 1'b1;
    step();
    mbus.ready = 1'b0; dbus.read = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-to-one arbiter that shares a single slow-memory port between the instruction cache and the data cache. It sits between the two cache instances' memory-side interfaces (read/write strobes, 128-bit line data, `[31:4]` line address, ready pulse) and one external slow memory. It grants one cache at a time and routes that cache's strobes, address and data to memory. It routes the memory's ready pulse back only to the granted cache, so each cache sees an unchanged slow-memory protocol.

## Interface
- No parameters; line width fixed at 128 bits, line address fixed at 28 bits (`[31:4]`).
- `clk`  in  1  system clock; all state updates on rising edge.
- `proc_reset`  in  1  synchronous, active-high reset.
- `i_read`, `i_write`  in  1 each  I-cache request strobes, held until `i_ready`.
- `i_addr`  in  28  I-cache line address `[31:4]`.
- `i_wdata`  in  128  I-cache write line.
- `i_rdata`  out  128  read line to I-cache.
- `i_ready`  out  1  completion pulse to I-cache.
- `d_read`, `d_write`, `d_addr`, `d_wdata`, `d_rdata`, `d_ready`: same set, widths and meanings as the `i_*` ports, for the D-cache.
- `mem_read`, `mem_write`  out  1 each  strobes to slow memory.
- `mem_addr`  out  28  line address to memory.
- `mem_wdata`  out  128  write line to memory.
- `mem_rdata`  in  128  read line from memory.
- `mem_ready`  in  1  memory completion pulse.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT_I: I-cache owns memory.
  - GRANT_D: D-cache owns memory.
- Register `last_grant` (0 = I, 1 = D) records the most recent granted side.
- IDLE transitions:
  - If only one side requests (read|write), go to that side's GRANT state.
  - If both request, the winner is set by the configuration (see Configuration).
  - If neither requests, stay in IDLE.
- GRANT_x transitions:
  - `mem_ready` = 1 → IDLE.
  - Granted side drops both strobes before `mem_ready` (abandoned request) → IDLE. The memory strobes fall in the same cycle.
  - Otherwise hold.
- Datapath in GRANT_x:
  - `mem_addr`/`mem_wdata` = x side's values.
  - `mem_write` = x_write.
  - `mem_read` = x_read & ~x_write; write wins if a requester asserts both.
- Datapath in IDLE: `mem_read`, `mem_write` = 0; `mem_addr`, `mem_wdata` = 0.
- Ready routing:
  - `i_ready` = `mem_ready` & (state == GRANT_I).
  - `d_ready` = `mem_ready` & (state == GRANT_D).
  - The non-granted side never sees ready.
- `i_rdata` and `d_rdata` are both driven by `mem_rdata` unconditionally; each cache samples only on its own ready.
- `last_grant` updates on every IDLE→GRANT transition.
- `mem_ready` arriving in IDLE is ignored; no ready is forwarded.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = 0 (I).
  - `mem_read` = `mem_write` = 0; `mem_addr` = 0, `mem_wdata` = 0.
  - `i_ready` = `d_ready` = 0.
  - `i_rdata`/`d_rdata` follow `mem_rdata`.
- Grant latency:
  - Request seen in IDLE at cycle t → state = GRANT at t+1.
  - The memory strobe is asserted from t+1; the arbiter adds one cycle of latency.
- Completion:
  - `mem_ready` at cycle t → `x_ready` in the same cycle t (combinational).
  - State = IDLE at t+1, with memory strobes low for at least one cycle.
  - The earliest next grant is t+2.
- Back-to-back: a cache doing write-back then allocate gets strobes low for exactly 1 cycle between the two transfers, provided no other side wins.
- Reset mid-transfer: `proc_reset` high at any edge forces IDLE next cycle, regardless of `mem_ready`; no ready is forwarded afterward.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on a tie in IDLE, grant the side ≠ `last_grant`. After reset the first tie goes to D.
- Not defined: fixed priority; D always wins ties. `last_grant` is still maintained but not used for arbitration.

## Test plan
- Reset, no requests → all memory strobes 0, both readies 0 for 10 cycles, state IDLE.
- Single I read:
  - Stimulus: `i_read` = 1, `i_addr` = 28'h0000010, memory returns 128'hA5..A5 with ready after 5 cycles.
  - Required: `mem_read` rises 1 cycle after request; `i_ready` pulses for exactly 1 cycle with `i_rdata` = 128'hA5..A5; `d_ready` stays 0.
- Simultaneous requests, twice in a row:
  - Stimulus: `i_read` and `d_write` asserted together, `d_addr` = 28'h0000040.
  - Required with the macro: D served first; I is granted 2 cycles after the D ready, and on the next tie I wins.
  - Required without the macro: D wins both ties.
- Back-to-back D:
  - Stimulus: `d_write` completes, then `d_read` is asserted the next cycle.
  - Required: memory strobes low for exactly 1 cycle between the two transfers; `mem_write` = 1 with `d_wdata` on the first, `mem_read` = 1 on the second.
- Reset mid-transfer: `proc_reset` pulsed 3 cycles into a GRANT_I read → memory strobes 0 on the next cycle; a later `mem_ready` produces no `i_ready`.
- Illegal both strobes: `d_read` = `d_write` = 1 → `mem_write` = 1, `mem_read` = 0 throughout the grant.
